axis_m_pkt: RTL and testbench
=============================

Name: axis_m_pkt

Overview:
- AXI-stream master stage that packetizes an internal valid/ready word stream.
- Buffers words in a DEPTH-entry FIFO, generates tlast from a runtime packet length, and drives an m_axis interface.
- Sits directly upstream of the axis slave receive stage: its m_axis_* ports connect to that stage's s_axis_* ports.
- Counts beats in the current packet and completed packets for status.

Parameters:
WIDTH  32  data width of data_in and m_axis_tdata
DEPTH  4   FIFO entries; power of two, >= 2
LEN_W  16  width of pkt_len, beat_cnt and pkt_cnt

Ports:
clk            input   1       single clock; all state on rising edge
rst_n          input   1       reset, asynchronous, active-low
valid_in       input   1       producer word valid
data_in        input   WIDTH   producer word
ready_out      output  1       stage can accept a word; = ~full
pkt_len        input   LEN_W   beats per packet; sampled on first beat of each packet
m_axis_tdata   output  WIDTH   head-of-FIFO data
m_axis_tvalid  output  1       = ~empty
m_axis_tready  input   1       downstream ready
m_axis_tlast   output  1       head-of-FIFO last flag
beat_cnt       output  LEN_W   beats accepted so far in the current input-side packet
pkt_cnt        output  LEN_W   packets fully sent on m_axis; wraps 2^LEN_W-1 -> 0
pkt_done       output  1       one-cycle pulse, cycle after tlast handshake

Behaviour:
- Reset (async assert, sync-to-clk deassert): FIFO empty, rd/wr pointers 0, occupancy 0, beat_cnt 0, len_q 0, pkt_cnt 0, pkt_done 0.
  - Outputs at reset: ready_out 1, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0.
- Storage: DEPTH x (WIDTH+1) entries holding {last, data}; occupancy counter is log2(DEPTH)+1 bits.
- push = valid_in & ready_out. pop = m_axis_tvalid & m_axis_tready.
- ready_out = ~full, registered-state only; no pop-through when full. A full FIFO with a pop this cycle still shows ready_out=0; it rises the next cycle.
- Latency: a word pushed in cycle N appears on m_axis in cycle N+1 at the earliest. tvalid never depends combinationally on valid_in.
- Output is first-word fall-through from registered storage. tdata/tlast are stable while tvalid=1 and tready=0, and tvalid never deasserts without a pop.
- Packet length:
  - eff_len = (beat_cnt==0) ? pkt_len : len_q.
  - On push with beat_cnt==0, len_q <= pkt_len.
  - pkt_len==0 is treated as 1.
  - pkt_len changes mid-packet are ignored until the next packet starts.
- Last generation on push:
  - If beat_cnt == eff_len-1 (or eff_len<=1), the stored last=1 and beat_cnt <= 0.
  - Otherwise the stored last=0 and beat_cnt <= beat_cnt+1.
  - No push: beat_cnt holds.
- Simultaneous push and pop: both take effect and occupancy is unchanged. From empty, the pushed word is visible the next cycle.
- On pop with m_axis_tlast=1: pkt_cnt <= pkt_cnt+1 (wraps), and pkt_done=1 for exactly the next cycle.
- Pointers wrap modulo DEPTH.
- pop when empty and push when full cannot occur by construction; the bench asserts this.
- Reset mid-packet: all buffered words are discarded, beat_cnt returns to 0, and the next pushed word starts a new packet. No partial tlast is emitted.

Test Plan:
1. pkt_len=3, push 6 words 0xA0..0xA5 back-to-back, tready=1 -> tdata A0..A5 from the cycle after the first push; tlast on A2 and A5; pkt_cnt 0->1->2; pkt_done pulses twice, each one cycle after its tlast beat.
2. DEPTH=4, tready=0, valid_in=1 for 6 cycles -> 4 words accepted, ready_out=0 from the cycle after the 4th push. tdata held at the first word. After tready=1, order is preserved and ready_out returns 1 one cycle after the first pop.
3. pkt_len=4 at first beat, changed to 2 after beat 2 -> tlast on beat 4; the next packet uses 2 (tlast on beat 6).
4. pkt_len=0, push 3 words -> tlast=1 on every beat, pkt_cnt=3, beat_cnt stays 0.
5. Random tready/valid_in over 1000 words, pkt_len=5 -> scoreboard checks in-order data, tlast every 5th beat, tdata stable under backpressure, pkt_cnt=200.
6. rst_n low for 1 cycle after 2 beats of a pkt_len=4 packet, FIFO holding 2 words -> tvalid=0 and beat_cnt=0 immediately. The next 4 pushes form one packet with tlast on the 4th; the pre-reset words are never output.

Source files
------------

// File: rtl/axis_m_pkt.sv
// AXI-stream master stage: buffers producer words in a small FIFO, tags each
// word with tlast from a runtime packet length, and counts sent packets.
module axis_m_pkt #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    input  logic [LEN_W-1:0] pkt_len,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [LEN_W-1:0] beat_cnt,
    output logic [LEN_W-1:0] pkt_cnt,
    output logic             pkt_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [WIDTH:0]   mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             pkt_done_q, pkt_done_d;

    logic             full, empty, push, pop, is_last;
    logic [WIDTH:0]   head;
    logic [LEN_W-1:0] eff_len;

    assign full          = (cnt_q == CW'(DEPTH));
    assign empty         = (cnt_q == '0);
    assign head          = mem_q[rd_ptr_q];
    assign ready_out     = ~full;
    assign m_axis_tvalid = ~empty;
    // Gate the head entry so a stale slot never shows on an idle bus.
    assign m_axis_tdata  = empty ? '0 : head[WIDTH-1:0];
    assign m_axis_tlast  = ~empty & head[WIDTH];
    assign push          = valid_in & ready_out;
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign beat_cnt      = beat_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign pkt_done      = pkt_done_q;

    // Length is latched on the first beat so mid-packet changes are ignored;
    // a length of 0 behaves like 1.
    assign eff_len = (beat_cnt_q == '0) ? pkt_len : len_q;
    assign is_last = (eff_len <= LEN_W'(1)) || (beat_cnt_q == eff_len - LEN_W'(1));

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        pkt_cnt_d  = pkt_cnt_q;
        pkt_done_d = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = {is_last, data_in};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            beat_cnt_d      = is_last ? '0 : beat_cnt_q + LEN_W'(1);
            if (beat_cnt_q == '0)
                len_d = pkt_len;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (head[WIDTH]) begin
                pkt_cnt_d  = pkt_cnt_q + LEN_W'(1);
                pkt_done_d = 1'b1;
            end
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            pkt_cnt_q  <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            pkt_cnt_q  <= pkt_cnt_d;
            pkt_done_q <= pkt_done_d;
        end
    end

endmodule

// File: tb/tb_axis_m_pkt.sv
// Scoreboard bench for axis_m_pkt: stimulus queues expected {last,data},
// a negedge monitor pops and checks every m_axis handshake.
module tb_axis_m_pkt;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_in = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             ready_out;
    logic [LEN_W-1:0] pkt_len = '0;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic             m_axis_tlast;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] pkt_cnt;
    logic             pkt_done;

    axis_m_pkt #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .ready_out(ready_out), .pkt_len(pkt_len), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt),
        .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [WIDTH:0]   exp_q [$];
    logic [LEN_W-1:0] mdl_pkt_cnt = '0;
    logic             exp_done = 1'b0;
    int               rdy_mode = 0;   // 0 low, 1 high, 2 random

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // tready driver: updates shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic             stall_v;
        logic [WIDTH-1:0] stall_d;
        logic             stall_l;
        logic [WIDTH:0]   e;
        stall_v = 1'b0;
        stall_d = '0;
        stall_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                mdl_pkt_cnt = '0;
                exp_done    = 1'b0;
                stall_v     = 1'b0;
            end else begin
                chk("pkt_cnt", 64'(pkt_cnt), 64'(mdl_pkt_cnt));
                chk("pkt_done", 64'(pkt_done), 64'(exp_done));
                chk("ready_out_vs_occ", 64'(ready_out), 64'(exp_q.size() < DEPTH));
                chk("tvalid_vs_occ", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
                if (stall_v) begin
                    chk("stall_tvalid", 64'(m_axis_tvalid), 64'(1));
                    chk("stall_tdata", 64'(m_axis_tdata), 64'(stall_d));
                    chk("stall_tlast", 64'(m_axis_tlast), 64'(stall_l));
                end
                exp_done = 1'b0;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_when_empty", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", 64'(m_axis_tdata), 64'(e[WIDTH-1:0]));
                        chk("tlast", 64'(m_axis_tlast), 64'(e[WIDTH]));
                        if (e[WIDTH]) begin
                            mdl_pkt_cnt = mdl_pkt_cnt + 1'b1;
                            exp_done    = 1'b1;
                        end
                    end
                end
                stall_v = m_axis_tvalid && !m_axis_tready;
                stall_d = m_axis_tdata;
                stall_l = m_axis_tlast;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic last);
        logic acc;
        acc = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = ready_out;
            @(posedge clk);
            #1;
        end
        if (acc) exp_q.push_back({last, d});
        else chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int c;
        valid_in = 1'b0;
        c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
        idle(2);
    endtask

    initial begin
        logic [LEN_W-1:0] base;
        // Reset state
        #1;
        chk("rst_ready_out", 64'(ready_out), 64'(1));
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_axis_tlast), 64'(0));
        chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
        chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_pkt_done", 64'(pkt_done), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // 1: pkt_len=3, six back-to-back words, tready high
        rdy_mode = 1;
        pkt_len  = 16'd3;
        idle(1);
        send(32'hA0, 0); send(32'hA1, 0); send(32'hA2, 1);
        send(32'hA3, 0); send(32'hA4, 0); send(32'hA5, 1);
        drain();
        chk("t1_pkt_cnt", 64'(pkt_cnt), 64'(2));
        chk("t1_beat_cnt", 64'(beat_cnt), 64'(0));

        // 2: backpressure fills the FIFO
        rdy_mode = 0;
        idle(1);
        begin
            int k;
            k = 0;
            for (int c = 0; c < 6; c++) begin
                valid_in = 1'b1;
                data_in  = 32'hB0 + 32'(k);
                @(negedge clk);
                chk("t2_ready_out", 64'(ready_out), 64'(c < 4));
                if (ready_out) begin
                    @(posedge clk);
                    #1;
                    exp_q.push_back({(k == 2), data_in});
                    k++;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        valid_in = 1'b0;
        chk("t2_tdata_held", 64'(m_axis_tdata), 64'hB0);
        rdy_mode = 1;
        @(negedge clk);
        chk("t2_ready_first_pop", 64'(ready_out), 64'(0));
        @(negedge clk);
        chk("t2_ready_after_pop", 64'(ready_out), 64'(1));
        @(posedge clk);
        #1;
        // B3 opened a new packet of 3; close it so later tests start clean.
        send(32'hB4, 0); send(32'hB5, 1);
        drain();

        // 3: length changes mid-packet
        pkt_len = 16'd4;
        send(32'hC0, 0); send(32'hC1, 0);
        pkt_len = 16'd2;
        send(32'hC2, 0); send(32'hC3, 1);
        send(32'hC4, 0); send(32'hC5, 1);
        drain();
        chk("t3_beat_cnt", 64'(beat_cnt), 64'(0));

        // 4: pkt_len=0 acts as 1
        base    = mdl_pkt_cnt;
        pkt_len = 16'd0;
        for (int i = 0; i < 3; i++) begin
            send(32'hD0 + 32'(i), 1);
            chk("t4_beat_cnt", 64'(beat_cnt), 64'(0));
        end
        drain();
        chk("t4_pkt_cnt", 64'(pkt_cnt), 64'(base + 16'd3));

        // 5: random traffic, pkt_len=5
        base     = mdl_pkt_cnt;
        pkt_len  = 16'd5;
        rdy_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send(32'h5000_0000 + 32'(i), (i % 5) == 4);
        end
        rdy_mode = 1;
        drain();
        chk("t5_pkt_cnt", 64'(pkt_cnt), 64'(base + 16'd200));

        // 6: reset mid-packet with two words buffered
        rdy_mode = 0;
        pkt_len  = 16'd4;
        idle(1);
        send(32'hE0, 0); send(32'hE1, 0);
        valid_in = 1'b0;
        chk("t6_beat_cnt_pre", 64'(beat_cnt), 64'(2));
        chk("t6_tvalid_pre", 64'(m_axis_tvalid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid_rst", 64'(m_axis_tvalid), 64'(0));
        chk("t6_beat_cnt_rst", 64'(beat_cnt), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 1;
        idle(1);
        send(32'hF0, 0); send(32'hF1, 0); send(32'hF2, 0); send(32'hF3, 1);
        drain();
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'(1));
        chk("t6_beat_cnt", 64'(beat_cnt), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
